// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared defaults and width helper for the contador counter
//
// Contents:
//   CONTADOR_WIDTH, CONTADOR_MAX, CONTADOR_DIV : default parameter values
//   contador_cnt_width(n) : register width needed to hold 0..n-1, never less than 1
package contador_pkg;

  localparam int CONTADOR_WIDTH = 4;
  localparam int CONTADOR_MAX   = 15;
  localparam int CONTADOR_DIV   = 1;

  // A ratio of 1 or 2 still needs one bit; $clog2 alone would give 0 for n=1.
  function automatic int contador_cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/contador_prescaler.sv
// rtl/contador_prescaler.sv - enable prescaler producing one tick every DIV enabled cycles
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-low
//   en   : count enable; the phase only advances while high
//   tick : combinational, high in the enabled cycle whose next edge ends a DIV period
module contador_prescaler
  import contador_pkg::*;
#(
  parameter int DIV = CONTADOR_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  if (DIV < 1) begin : g_bad_div
    $error("contador_prescaler: DIV must be >= 1");
  end

  localparam int PW = contador_cnt_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  // With DIV=1 the phase register stays at 0 forever (LAST is 0, so every
  // enabled cycle reloads 0); synthesis reduces it to a constant.
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          at_last;

  assign at_last = (presc_q == LAST);

  always_comb begin
    presc_d = presc_q;
    if (en) begin
      presc_d = at_last ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = en & at_last;

endmodule

// File: rtl/contador.sv
// rtl/contador.sv - modulo up-counter with clock enable, prescaler and terminal-count pulse
//
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous reset, active-low (0 = reset)
//   en       : count enable, sampled on the rising edge
//   cont_out : registered count value, 0..MAX
//   tc       : combinational terminal-count pulse, high in the cycle whose edge wraps to 0
module contador
  import contador_pkg::*;
#(
  parameter int WIDTH = CONTADOR_WIDTH,
  parameter int MAX   = CONTADOR_MAX,
  parameter int DIV   = CONTADOR_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] cont_out,
  output logic             tc
);

  if (WIDTH < 1) begin : g_bad_width
    $error("contador: WIDTH must be >= 1");
  end

  if (MAX < 1 || longint'(MAX) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("contador: MAX must satisfy 0 < MAX <= 2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic             tick;
  logic             at_max;
  logic [WIDTH-1:0] cont_q;
  logic [WIDTH-1:0] cont_d;

  contador_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // >= rather than == so a corrupted value above MAX recovers by wrapping.
  assign at_max = (cont_q >= MAX_V);

  always_comb begin
    cont_d = cont_q;
    if (tick) begin
      cont_d = at_max ? '0 : cont_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign cont_out = cont_q;
  // tick already carries en and the last-prescale-phase condition.
  assign tc       = rst & tick & at_max;

endmodule

// File: tb/tb_contador.sv
// tb/tb_contador.sv - directed vector bench for contador (default, MAX=9 and DIV=3 instances)
module tb_contador;

  logic       clk;
  logic       rst_a, en_a, tc_a;
  logic [3:0] cnt_a;
  logic       rst_b, en_b, tc_b;
  logic [3:0] cnt_b;
  logic       rst_c, en_c, tc_c;
  logic [3:0] cnt_c;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic rst;
    logic en;
    int   exp_tc;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[$];

  contador dut_def (
    .clk      (clk),
    .rst      (rst_a),
    .en       (en_a),
    .cont_out (cnt_a),
    .tc       (tc_a)
  );

  contador #(.MAX(9)) dut_m9 (
    .clk      (clk),
    .rst      (rst_b),
    .en       (en_b),
    .cont_out (cnt_b),
    .tc       (tc_b)
  );

  contador #(.DIV(3)) dut_d3 (
    .clk      (clk),
    .rst      (rst_c),
    .en       (en_c),
    .cont_out (cnt_c),
    .tc       (tc_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input int t, input int c);
    vec_t v;
    v.rst = r;
    v.en = e;
    v.exp_tc = t;
    v.exp_cnt = c;
    vecs.push_back(v);
  endtask

  initial begin
    rst_a = 1'b0; en_a = 1'b1;
    rst_b = 1'b0; en_b = 1'b0;
    rst_c = 1'b0; en_c = 1'b0;

    // ---------------- default instance table ----------------
    add(0, 1, 0, 0);
    add(0, 1, 0, 0);
    for (int k = 1; k <= 17; k++) add(1, 1, (k == 16) ? 1 : 0, k % 16);
    for (int k = 2; k <= 5; k++) add(1, 1, 0, k);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 5);
    add(1, 1, 0, 6);
    for (int k = 7; k <= 15; k++) add(1, 1, 0, k);
    add(1, 0, 0, 15);   // at MAX but disabled: no pulse, no wrap
    add(1, 1, 1, 0);
    add(1, 1, 0, 1);
    add(0, 1, 0, 0);

    #1;
    check("reset_tc_async", int'(tc_a), 0);
    check("reset_cnt_async", int'(cnt_a), 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_a = vecs[i].rst;
      en_a  = vecs[i].en;
      #1;
      check($sformatf("tbl[%0d].tc", i), int'(tc_a), vecs[i].exp_tc);
      @(posedge clk);
      #1;
      check($sformatf("tbl[%0d].cnt", i), int'(cnt_a), vecs[i].exp_cnt);
    end

    // ---------------- async reset mid-period at count 9 ----------------
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      rst_a = 1'b1;
      en_a  = 1'b1;
      @(posedge clk);
    end
    #1;
    check("midrst_pre_cnt", int'(cnt_a), 9);
    #2;
    rst_a = 1'b0;
    #1;
    check("midrst_cnt_cleared", int'(cnt_a), 0);
    check("midrst_tc_low", int'(tc_a), 0);
    @(negedge clk);
    rst_a = 1'b1;
    en_a  = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_first_inc", int'(cnt_a), 1);

    // ---------------- MAX=9 instance ----------------
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      rst_b = 1'b1;
      en_b  = 1'b1;
      #1;
      check($sformatf("m9[%0d].tc", k), int'(tc_b), (k == 10) ? 1 : 0);
      @(posedge clk);
      #1;
      check($sformatf("m9[%0d].cnt", k), int'(cnt_b), k % 10);
    end

    // ---------------- DIV=3 instance ----------------
    // Before enabled edge k: count=((k-1)/3)%16, phase=(k-1)%3.
    for (int k = 1; k <= 48; k++) begin
      if (k == 5) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          en_c = 1'b0;
          #1;
          check($sformatf("d3_freeze[%0d].tc", g), int'(tc_c), 0);
          @(posedge clk);
          #1;
          check($sformatf("d3_freeze[%0d].cnt", g), int'(cnt_c), 1);
        end
      end
      @(negedge clk);
      rst_c = 1'b1;
      en_c  = 1'b1;
      #1;
      check($sformatf("d3[%0d].tc", k), int'(tc_c),
            (((k - 1) % 3 == 2) && (((k - 1) / 3) % 16 == 15)) ? 1 : 0);
      @(posedge clk);
      #1;
      check($sformatf("d3[%0d].cnt", k), int'(cnt_c), (k / 3) % 16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
